// File: rtl/cdb_pkg.sv
// Shared CDB constants: bus geometry, the "value ready" label and station ids.
// Used by the arbiter, the pick logic and every station that snoops the bus.
package cdb_pkg;

   localparam int N_REQ   = 3;
   localparam int LABEL_W = 5;
   localparam int DATA_W  = 32;

   localparam logic [LABEL_W-1:0] LABEL_READY = '0;

   localparam logic [LABEL_W-1:0] LBL_LOAD0 = 5'd1;
   localparam logic [LABEL_W-1:0] LBL_LOAD1 = 5'd2;
   localparam logic [LABEL_W-1:0] LBL_ADD0  = 5'd3;
   localparam logic [LABEL_W-1:0] LBL_ADD1  = 5'd4;
   localparam logic [LABEL_W-1:0] LBL_ADD2  = 5'd5;
   localparam logic [LABEL_W-1:0] LBL_MUL0  = 5'd6;
   localparam logic [LABEL_W-1:0] LBL_MUL1  = 5'd7;

   function automatic int wrap_inc(input int g, input int n);
      return (g == n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Round-robin pick: first set bit of elig at or after ptr, wrapping to 0.
// Purely combinational; returns one-hot grant, its index and a found flag.
module cdb_rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  elig,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N)
            j = j - N;
         if (!any && elig[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = PW'(j);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one round-robin grant per cycle, registered broadcast.
// Define CDB_MEM_PRIORITY_EN to favour producer 0 with a 2-grant streak limit.
module cdb_arbiter #(
   parameter int N_REQ   = cdb_pkg::N_REQ,
   parameter int LABEL_W = cdb_pkg::LABEL_W,
   parameter int DATA_W  = cdb_pkg::DATA_W
) (
   input  logic                       clk,
   input  logic                       RST,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*LABEL_W-1:0]   reqLabel,
   input  logic [N_REQ*DATA_W-1:0]    reqData,
   output logic [N_REQ-1:0]           ack,
   output logic                       BCEN,
   output logic [LABEL_W-1:0]         BClabel,
   output logic [DATA_W-1:0]          BCdata,
   output logic                       badLabel
);

   import cdb_pkg::*;

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [LABEL_W-1:0] lbl [N_REQ];
   logic [DATA_W-1:0]  dat [N_REQ];
   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   pick_elig;
   logic [N_REQ-1:0]   rr_grant;
   logic [PW-1:0]      rr_idx;
   logic               rr_any;
   logic [N_REQ-1:0]   sel_grant;
   logic [PW-1:0]      sel_idx;
   logic               sel_any;
   logic               advance;
   logic               bad_seen;
   logic [PW-1:0]      ptr;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         lbl[i]  = reqLabel[i*LABEL_W +: LABEL_W];
         dat[i]  = reqData[i*DATA_W +: DATA_W];
         elig[i] = req[i] && (lbl[i] != LABEL_W'(LABEL_READY));
      end
   end

   assign bad_seen = |(req & ~elig);

   cdb_rr_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_pick (
      .elig  (pick_elig),
      .ptr   (ptr),
      .grant (rr_grant),
      .idx   (rr_idx),
      .any   (rr_any)
   );

`ifdef CDB_MEM_PRIORITY_EN
   logic [1:0] streak;
   logic       skip0;
   logic       mem_win;

   // Producer 0 yields one slot after two straight wins if anyone else waits.
   assign skip0     = (streak >= 2'd2) && (|elig[N_REQ-1:1]);
   assign mem_win   = elig[0] && !skip0;
   assign pick_elig = skip0 ? (elig & ~N_REQ'(1)) : elig;
   assign sel_grant = mem_win ? N_REQ'(1) : rr_grant;
   assign sel_idx   = mem_win ? '0 : rr_idx;
   assign sel_any   = mem_win | rr_any;
   assign advance   = rr_any && !mem_win;

   always_ff @(posedge clk) begin
      if (RST)
         streak <= '0;
      else if (mem_win)
         streak <= (streak >= 2'd2) ? 2'd2 : streak + 2'd1;
      else
         streak <= '0;
   end
`else
   assign pick_elig = elig;
   assign sel_grant = rr_grant;
   assign sel_idx   = rr_idx;
   assign sel_any   = rr_any;
   assign advance   = rr_any;
`endif

   assign ack = RST ? '0 : sel_grant;

   always_ff @(posedge clk) begin
      if (RST) begin
         BCEN     <= 1'b0;
         BClabel  <= '0;
         BCdata   <= '0;
         badLabel <= 1'b0;
         ptr      <= '0;
      end else begin
         BCEN <= sel_any;
         if (sel_any) begin
            BClabel <= lbl[sel_idx];
            BCdata  <= dat[sel_idx];
         end
         if (advance)
            ptr <= PW'(wrap_inc(int'(sel_idx), N_REQ));
         if (bad_seen)
            badLabel <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expectations,
// a negedge monitor pops and compares ack, broadcast and badLabel.
module tb_cdb_arbiter;

   localparam int N  = 3;
   localparam int LW = 5;
   localparam int DW = 32;

   logic            clk;
   logic            RST;
   logic [N-1:0]    req;
   logic [N*LW-1:0] reqLabel;
   logic [N*DW-1:0] reqData;
   logic [N-1:0]    ack;
   logic            BCEN;
   logic [LW-1:0]   BClabel;
   logic [DW-1:0]   BCdata;
   logic            badLabel;

   cdb_arbiter u_dut (
      .clk      (clk),
      .RST      (RST),
      .req      (req),
      .reqLabel (reqLabel),
      .reqData  (reqData),
      .ack      (ack),
      .BCEN     (BCEN),
      .BClabel  (BClabel),
      .BCdata   (BCdata),
      .badLabel (badLabel)
   );

   typedef struct {
      int          due;
      logic [N-1:0] ack;
   } ack_exp_t;

   typedef struct {
      int            due;
      logic          en;
      logic [LW-1:0] lab;
      logic [DW-1:0] dat;
      logic          bad;
   } bc_exp_t;

   ack_exp_t ackq[$];
   bc_exp_t  bcq[$];
   int       cyc = 0;
   int       n_vec = 0;
   int       n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      ack_exp_t a;
      bc_exp_t  b;
      if (ackq.size() != 0 && ackq[0].due == cyc) begin
         a = ackq.pop_front();
         n_vec++;
         if (ack !== a.ack) begin
            n_bad++;
            $display("FAIL ack cyc=%0d got=%b want=%b", cyc, ack, a.ack);
         end
      end
      if (bcq.size() != 0 && bcq[0].due == cyc) begin
         b = bcq.pop_front();
         n_vec++;
         if (BCEN !== b.en || BClabel !== b.lab ||
             BCdata !== b.dat || badLabel !== b.bad) begin
            n_bad++;
            $display("FAIL bcast cyc=%0d got=%b/%0d/%h/%b want=%b/%0d/%h/%b",
                     cyc, BCEN, BClabel, BCdata, badLabel,
                     b.en, b.lab, b.dat, b.bad);
         end
      end
   end

   task automatic vec(
      input logic          r,
      input logic [N-1:0]  rq,
      input logic [LW-1:0] l0, l1, l2,
      input logic [DW-1:0] d0, d1, d2,
      input logic [N-1:0]  eack,
      input logic          een,
      input logic [LW-1:0] elab,
      input logic [DW-1:0] edat,
      input logic          ebad
   );
      ack_exp_t a;
      bc_exp_t  b;
      @(posedge clk);
      #1;
      RST      = r;
      req      = rq;
      reqLabel = {l2, l1, l0};
      reqData  = {d2, d1, d0};
      a.due = cyc;
      a.ack = eack;
      ackq.push_back(a);
      b.due = cyc + 1;
      b.en  = een;
      b.lab = elab;
      b.dat = edat;
      b.bad = ebad;
      bcq.push_back(b);
   endtask

   localparam logic [DW-1:0] A0 = 32'h1111_1111;
   localparam logic [DW-1:0] A1 = 32'h2222_2222;
   localparam logic [DW-1:0] A2 = 32'h3333_3333;
   localparam logic [DW-1:0] DB = 32'hDEAD_BEEF;
   localparam logic [DW-1:0] D4 = 32'h0000_0044;
   localparam logic [DW-1:0] D6 = 32'h0000_0066;
   localparam logic [DW-1:0] D7 = 32'h0000_0077;
   localparam logic [DW-1:0] D8 = 32'h0000_0088;

   initial begin
      RST      = 1'b1;
      req      = '0;
      reqLabel = '0;
      reqData  = '0;

      vec(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
`ifdef CDB_MEM_PRIORITY_EN
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b001, 1, 7, D7, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b001, 1, 7, D7, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b010, 1, 8, D8, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b001, 1, 7, D7, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b001, 1, 7, D7, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b010, 1, 8, D8, 0);
      vec(0, 3'b000, 7, 8, 0, D7, D8, 0, 3'b000, 0, 8, D8, 0);
      vec(1, 3'b011, 7, 8, 0, D7, D8, 0, 3'b000, 0, 0, 0, 0);
`else
      // rotation 1,2,3,1 then reset mid-stream
      vec(0, 3'b111, 1, 2, 3, A0, A1, A2, 3'b001, 1, 1, A0, 0);
      vec(0, 3'b111, 1, 2, 3, A0, A1, A2, 3'b010, 1, 2, A1, 0);
      vec(0, 3'b111, 1, 2, 3, A0, A1, A2, 3'b100, 1, 3, A2, 0);
      vec(0, 3'b111, 1, 2, 3, A0, A1, A2, 3'b001, 1, 1, A0, 0);
      vec(1, 3'b111, 1, 2, 3, A0, A1, A2, 3'b000, 0, 0, 0, 0);
      // single producer, then idle holds label/data
      vec(0, 3'b010, 1, 5, 3, A0, DB, A2, 3'b010, 1, 5, DB, 0);
      vec(0, 3'b000, 1, 5, 3, A0, DB, A2, 3'b000, 0, 5, DB, 0);
      // wrap from ptr=2
      vec(0, 3'b001, 4, 5, 6, D4, DB, D6, 3'b001, 1, 4, D4, 0);
      vec(0, 3'b101, 4, 5, 6, D4, DB, D6, 3'b100, 1, 6, D6, 0);
      vec(0, 3'b101, 4, 5, 6, D4, DB, D6, 3'b001, 1, 4, D4, 0);
      // label 0 is never granted and sets sticky badLabel
      vec(0, 3'b101, 4, 5, 0, D4, DB, D6, 3'b001, 1, 4, D4, 1);
      vec(0, 3'b000, 4, 5, 0, D4, DB, D6, 3'b000, 0, 4, D4, 1);
      vec(0, 3'b100, 4, 5, 0, D4, DB, D6, 3'b000, 0, 4, D4, 1);
      vec(1, 3'b000, 4, 5, 0, D4, DB, D6, 3'b000, 0, 0, 0, 0);
      // two producers alternate
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b001, 1, 7, D7, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b010, 1, 8, D8, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b001, 1, 7, D7, 0);
      vec(0, 3'b011, 7, 8, 0, D7, D8, 0, 3'b010, 1, 8, D8, 0);
      vec(0, 3'b000, 7, 8, 0, D7, D8, 0, 3'b000, 0, 8, D8, 0);
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (ackq.size() != 0 || bcq.size() != 0) begin
         n_bad++;
         $display("FAIL drain left=%0d/%0d want=0/0", ackq.size(), bcq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
